// File: rtl/micro_sequencer_if.sv
// Sequencer <-> datapath/ROM bundle: instruction fields and memory
// handshake in, register-transfer codes and status out.
interface micro_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       opcode;
    logic [5:0]       func;
    logic             mem_ready;
    logic [3:0]       rt_one;
    logic [3:0]       rt_two;
    logic             wwd_valid;
    logic             is_halted;
    logic             illegal;
    logic [CNT_W-1:0] num_inst;

    modport master (
        output opcode, func, mem_ready,
        input  rt_one, rt_two, wwd_valid,
        input  is_halted, illegal, num_inst
    );

    modport slave (
        input  opcode, func, mem_ready,
        output rt_one, rt_two, wwd_valid,
        output is_halted, illegal, num_inst
    );
endinterface

// File: rtl/micro_sequencer.sv
// Moore FSM stepping the multi-cycle TSC CPU (IF/ID/EX/MEM/WB/HALT).
// Define ILLEGAL_TRAP_EN to halt and flag on illegal instructions.
module micro_sequencer #(
    parameter int             CNT_W  = 16,
    parameter logic [3:0]     RT_NOP = 4'd14
) (
    input  logic              clk,
    input  logic              reset,
    micro_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        C_NOP, C_BR, C_IALU, C_LWD, C_SWD, C_JMP, C_JAL,
        C_RALU, C_JPR, C_JRL, C_WWD, C_HLT, C_ILL
    } cls_e;

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rt1, rt2;
    logic             wwd;

    function automatic cls_e decode(input logic [3:0] op,
                                    input logic [5:0] fn);
        cls_e c;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: c = C_BR;
            4'd4, 4'd5, 4'd6:       c = C_IALU;
            4'd7:                   c = C_LWD;
            4'd8:                   c = C_SWD;
            4'd9:                   c = C_JMP;
            4'd10:                  c = C_JAL;
            4'd15: begin
                if (fn <= 6'd7) c = C_RALU;
                else begin
                    case (fn)
                        6'd25:   c = C_JPR;
                        6'd26:   c = C_JRL;
                        6'd28:   c = C_WWD;
                        6'd29:   c = C_HLT;
                        default: c = C_ILL;
                    endcase
                end
            end
            default:                c = C_ILL;
        endcase
        return c;
    endfunction

`ifdef ILLEGAL_TRAP_EN
    logic ill_q, ill_d;
`endif

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        rt1     = RT_NOP;
        rt2     = RT_NOP;
        wwd     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        ill_d   = ill_q;
`endif
        case (state_q)
            S_IF: begin
                rt1 = 4'd0;
                if (bus.mem_ready) state_d = S_ID;
            end
            S_ID: begin
                rt1     = 4'd1;
                rt2     = 4'd2;
                cls_d   = decode(bus.opcode, bus.func);
                state_d = S_EX;
            end
            S_EX: begin
                state_d = S_IF;
                case (cls_q)
                    C_JMP:  rt1 = 4'd3;
                    C_JAL:  begin rt1 = 4'd3; rt2 = 4'd4; end
                    C_JPR:  rt1 = 4'd5;
                    C_JRL:  begin rt1 = 4'd5; rt2 = 4'd4; end
                    C_BR:   rt1 = 4'd8;
                    C_WWD:  wwd = 1'b1;
                    C_RALU: begin rt1 = 4'd7; state_d = S_WB; end
                    C_IALU: begin rt1 = 4'd6; state_d = S_WB; end
                    C_LWD,
                    C_SWD:  begin rt1 = 4'd6; state_d = S_MEM; end
                    C_HLT:  state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                    C_ILL:  begin state_d = S_HALT; ill_d = 1'b1; end
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                rt1 = (cls_q == C_LWD) ? 4'd11 : 4'd12;
                if (bus.mem_ready)
                    state_d = (cls_q == C_LWD) ? S_WB : S_IF;
            end
            S_WB: begin
                state_d = S_IF;
                case (cls_q)
                    C_RALU:  rt1 = 4'd9;
                    C_IALU:  rt1 = 4'd10;
                    C_LWD:   rt1 = 4'd13;
                    default: ;
                endcase
            end
            S_HALT: ;
            default: state_d = S_IF;
        endcase
    end

    // An instruction retires when control returns to IF or enters HALT.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S_IF && (state_q == S_EX || state_q == S_MEM
                                 || state_q == S_WB))
            || (state_d == S_HALT && state_q != S_HALT))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            cls_q   <= C_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ill_q <= 1'b0;
        else       ill_q <= ill_d;
    end
    assign bus.illegal = ill_q;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.rt_one    = rt1;
    assign bus.rt_two    = rt2;
    assign bus.wwd_valid = wwd;
    assign bus.is_halted = (state_q == S_HALT);
    assign bus.num_inst  = cnt_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed table-driven bench for micro_sequencer, plus reset,
// illegal-op and counter-wrap sequences.
module tb_micro_sequencer;
    logic clk = 1'b0;
    logic reset;
    logic reset_s;
    always #5 clk = ~clk;

    micro_sequencer_if #(.CNT_W(16)) bus ();
    micro_sequencer_if #(.CNT_W(4))  sbus ();

    micro_sequencer #(.CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    micro_sequencer #(.CNT_W(4)) dut_s (
        .clk   (clk),
        .reset (reset_s),
        .bus   (sbus.slave)
    );

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic        wwd;
        logic        hlt;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, got, exp);
    endtask

    task automatic add(input logic [3:0] op, input logic [5:0] fn,
                       input logic mr, input logic [3:0] r1,
                       input logic [3:0] r2, input logic w,
                       input logic h, input logic il,
                       input logic [15:0] c);
        vec_t v;
        v.op = op; v.fn = fn; v.mr = mr; v.r1 = r1; v.r2 = r2;
        v.wwd = w; v.hlt = h; v.ill = il; v.cnt = c;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] outs();
        return {5'd0, bus.rt_one, bus.rt_two, bus.wwd_valid,
                bus.is_halted, bus.illegal, bus.num_inst};
    endfunction

    task automatic run(input vec_t v, input string nm);
        bus.opcode    = v.op;
        bus.func      = v.fn;
        bus.mem_ready = v.mr;
        #1;
        chk(nm, outs(), {5'd0, v.r1, v.r2, v.wwd, v.hlt, v.ill, v.cnt});
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] op, input logic [5:0] fn,
                        input logic mr, input logic [3:0] r1,
                        input logic [3:0] r2, input logic w,
                        input logic h, input logic il,
                        input logic [15:0] c, input string nm);
        vec_t v;
        v.op = op; v.fn = fn; v.mr = mr; v.r1 = r1; v.r2 = r2;
        v.wwd = w; v.hlt = h; v.ill = il; v.cnt = c;
        run(v, nm);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        reset_s = 1'b1;
        bus.opcode = 4'd0; bus.func = 6'd0; bus.mem_ready = 1'b0;
        sbus.opcode = 4'd15; sbus.func = 6'd28; sbus.mem_ready = 1'b1;

        // ADI
        add(4, 0, 1,  0, 14, 0, 0, 0, 0);
        add(4, 0, 1,  1,  2, 0, 0, 0, 0);
        add(4, 0, 0,  6, 14, 0, 0, 0, 0);
        add(4, 0, 0, 10, 14, 0, 0, 0, 0);
        // LWD with a 3-cycle memory stall
        add(7, 0, 1,  0, 14, 0, 0, 0, 1);
        add(7, 0, 1,  1,  2, 0, 0, 0, 1);
        add(7, 0, 1,  6, 14, 0, 0, 0, 1);
        add(7, 0, 0, 11, 14, 0, 0, 0, 1);
        add(7, 0, 0, 11, 14, 0, 0, 0, 1);
        add(7, 0, 0, 11, 14, 0, 0, 0, 1);
        add(7, 0, 1, 11, 14, 0, 0, 0, 1);
        add(7, 0, 1, 13, 14, 0, 0, 0, 1);
        // JRL with a fetch stall
        add(15, 26, 0, 0, 14, 0, 0, 0, 2);
        add(15, 26, 1, 0, 14, 0, 0, 0, 2);
        add(15, 26, 1, 1,  2, 0, 0, 0, 2);
        add(15, 26, 1, 5,  4, 0, 0, 0, 2);
        // SWD
        add(8, 0, 1,  0, 14, 0, 0, 0, 3);
        add(8, 0, 1,  1,  2, 0, 0, 0, 3);
        add(8, 0, 1,  6, 14, 0, 0, 0, 3);
        add(8, 0, 1, 12, 14, 0, 0, 0, 3);
        // WWD
        add(15, 28, 1,  0, 14, 0, 0, 0, 4);
        add(15, 28, 1,  1,  2, 0, 0, 0, 4);
        add(15, 28, 1, 14, 14, 1, 0, 0, 4);
        // RALU (func 3)
        add(15, 3, 1, 0, 14, 0, 0, 0, 5);
        add(15, 3, 1, 1,  2, 0, 0, 0, 5);
        add(15, 3, 1, 7, 14, 0, 0, 0, 5);
        add(15, 3, 1, 9, 14, 0, 0, 0, 5);
        // BR, JMP, JAL, JPR
        add(2, 0, 1, 0, 14, 0, 0, 0, 6);
        add(2, 0, 1, 1,  2, 0, 0, 0, 6);
        add(2, 0, 1, 8, 14, 0, 0, 0, 6);
        add(9, 0, 1, 0, 14, 0, 0, 0, 7);
        add(9, 0, 1, 1,  2, 0, 0, 0, 7);
        add(9, 0, 1, 3, 14, 0, 0, 0, 7);
        add(10, 0, 1, 0, 14, 0, 0, 0, 8);
        add(10, 0, 1, 1,  2, 0, 0, 0, 8);
        add(10, 0, 1, 3,  4, 0, 0, 0, 8);
        add(15, 25, 1, 0, 14, 0, 0, 0, 9);
        add(15, 25, 1, 1,  2, 0, 0, 0, 9);
        add(15, 25, 1, 5, 14, 0, 0, 0, 9);
        // HLT, then HALT absorbs regardless of inputs
        add(15, 29, 1,  0, 14, 0, 0, 0, 10);
        add(15, 29, 1,  1,  2, 0, 0, 0, 10);
        add(15, 29, 1, 14, 14, 0, 0, 0, 10);
        add(15, 29, 0, 14, 14, 0, 1, 0, 11);
        add(4,   0, 1, 14, 14, 0, 1, 0, 11);
        add(7,   0, 1, 14, 14, 0, 1, 0, 11);

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", outs(), {5'd0, 4'd0, 4'd14, 3'b000, 16'd0});
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i], $sformatf("vec%0d", i));

        // asynchronous reset out of HALT
        reset = 1'b1;
        #1;
        chk("reset_from_halt", outs(),
            {5'd0, 4'd0, 4'd14, 3'b000, 16'd0});
        @(posedge clk);
        #1;
        reset = 1'b0;

        // illegal opcode 11
        step(11, 0, 1,  0, 14, 0, 0, 0, 0, "ill_if");
        step(11, 0, 1,  1,  2, 0, 0, 0, 0, "ill_id");
        step(11, 0, 1, 14, 14, 0, 0, 0, 0, "ill_ex");
`ifdef ILLEGAL_TRAP_EN
        step(4, 0, 1, 14, 14, 0, 1, 1, 1, "ill_halt");
        step(4, 0, 1, 14, 14, 0, 1, 1, 1, "ill_halt_hold");
`else
        step(4, 0, 1, 0, 14, 0, 0, 0, 1, "ill_back_if");
`endif

        // reset mid-MEM stall discards the in-flight LWD
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4, 0, 1,  0, 14, 0, 0, 0, 0, "m_adi_if");
        step(4, 0, 1,  1,  2, 0, 0, 0, 0, "m_adi_id");
        step(4, 0, 1,  6, 14, 0, 0, 0, 0, "m_adi_ex");
        step(4, 0, 1, 10, 14, 0, 0, 0, 0, "m_adi_wb");
        step(7, 0, 1,  0, 14, 0, 0, 0, 1, "m_lwd_if");
        step(7, 0, 1,  1,  2, 0, 0, 0, 1, "m_lwd_id");
        step(7, 0, 1,  6, 14, 0, 0, 0, 1, "m_lwd_ex");
        step(7, 0, 0, 11, 14, 0, 0, 0, 1, "m_lwd_mem");
        bus.mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("reset_mid_mem", outs(),
            {5'd0, 4'd0, 4'd14, 3'b000, 16'd0});
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(4, 0, 1, 0, 14, 0, 0, 0, 0, "post_rst_if");
        step(4, 0, 1, 1,  2, 0, 0, 0, 0, "post_rst_id");

        // 4-bit counter wraps 15 -> 0 after 16 WWDs
        reset_s = 1'b0;
        pulses = 0;
        for (int i = 0; i < 48; i++) begin
            if (sbus.wwd_valid) pulses++;
            if (i == 45)
                chk("wrap_pre", 32'(sbus.num_inst), 32'd15);
            @(posedge clk);
            #1;
        end
        chk("wrap_zero", 32'(sbus.num_inst), 32'd0);
        chk("wwd_pulses", 32'(pulses), 32'd16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
